// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stages: checkpoint sizing,
// kill-mask type and the tag-vs-mask match helper.
package pipe_pkg;

    localparam int CHECKPOINT_WIDTH = 2;
    localparam int NUM_CHECKPOINTS  = 2 ** CHECKPOINT_WIDTH;

    typedef logic [NUM_CHECKPOINTS-1:0]  kill_mask_t;
    typedef logic [CHECKPOINT_WIDTH-1:0] ckpt_t;

    // True when the entry's checkpoint tag is selected by the kill mask.
    function automatic logic ckpt_hit(input kill_mask_t mask, input ckpt_t tag);
        return mask[tag];
    endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// One storage slot of the elastic stage: valid bit, checkpoint tag and payload.
// Controls, in priority order: kill (invalidate, optionally zero contents),
// load (capture new entry), empty (invalidate only), otherwise hold.
module pipe_skid_entry #(
    parameter int DATA_WIDTH   = 64,
    parameter int TAG_WIDTH    = 2,
    parameter bit ZERO_ON_KILL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  kill_en,
    input  logic                  load_en,
    input  logic                  empty_en,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [TAG_WIDTH-1:0]  load_tag,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [TAG_WIDTH-1:0]  tag
);

    // Slot state update; kill beats load so a flushed slot never captures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= {DATA_WIDTH{1'b0}};
            tag   <= {TAG_WIDTH{1'b0}};
        end else if (kill_en) begin
            valid <= 1'b0;
            if (ZERO_ON_KILL) begin
                data <= {DATA_WIDTH{1'b0}};
                tag  <= {TAG_WIDTH{1'b0}};
            end
        end else if (load_en) begin
            valid <= 1'b1;
            data  <= load_data;
            tag   <= load_tag;
        end else if (empty_en) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline stage: valid/ready handshake backed by a head (H) and
// skid (S) slot, with global flush and per-checkpoint selective kill.
// o_Ready comes from a flop so no combinational path runs from i_Ready.
module pipe_elastic_stage #(
    parameter int DATA_WIDTH       = 64,
    parameter int CHECKPOINT_WIDTH = pipe_pkg::CHECKPOINT_WIDTH,
    parameter int NUM_CHECKPOINTS  = pipe_pkg::NUM_CHECKPOINTS,
    parameter bit ZERO_ON_FLUSH    = 1'b1,
    parameter int COUNT_WIDTH      = 16
) (
    input  logic                        i_Clk,
    input  logic                        i_Reset_n,
    input  logic                        i_Flush,
    input  logic                        i_Kill,
    input  logic [NUM_CHECKPOINTS-1:0]  i_Kill_Mask,
    input  logic                        i_Valid,
    output logic                        o_Ready,
    input  logic [DATA_WIDTH-1:0]       i_Data,
    input  logic [CHECKPOINT_WIDTH-1:0] i_Checkpoint,
    output logic                        o_Valid,
    input  logic                        i_Ready,
    output logic [DATA_WIDTH-1:0]       o_Data,
    output logic [CHECKPOINT_WIDTH-1:0] o_Checkpoint,
    output logic [1:0]                  o_Occupancy,
    input  logic                        i_Count_Clear,
    output logic [COUNT_WIDTH-1:0]      o_Stall_Count
);

    logic                        h_valid_s, s_valid_s;
    logic [DATA_WIDTH-1:0]       h_data_s, s_data_s;
    logic [CHECKPOINT_WIDTH-1:0] h_tag_s, s_tag_s;

    logic                        ready_r;
    logic [COUNT_WIDTH-1:0]      stall_cnt_r;

    logic h_hit_s, s_hit_s, in_hit_s;
    logic h_live_s, s_live_s, in_live_s, h_stays_s;
    logic h_kill_en_s, h_load_en_s, h_empty_en_s;
    logic s_kill_en_s, s_load_en_s, s_empty_en_s, s_hold_s;
    logic [DATA_WIDTH-1:0]       h_load_data_s;
    logic [CHECKPOINT_WIDTH-1:0] h_load_tag_s;

    // Kill decode for head, skid and the incoming entry; a killed head stays hidden.
    always_comb begin
        h_hit_s   = i_Kill && pipe_pkg::ckpt_hit(i_Kill_Mask, h_tag_s);
        s_hit_s   = i_Kill && pipe_pkg::ckpt_hit(i_Kill_Mask, s_tag_s);
        in_hit_s  = i_Kill && pipe_pkg::ckpt_hit(i_Kill_Mask, i_Checkpoint);
        h_live_s  = h_valid_s && !h_hit_s;
        s_live_s  = s_valid_s && !s_hit_s;
        in_live_s = i_Valid && ready_r && !in_hit_s;
        h_stays_s = h_live_s && !i_Ready;
    end

    // Steering: survivors compact toward H in arrival order; flush clears both slots.
    always_comb begin
        h_kill_en_s   = 1'b0;
        h_load_en_s   = 1'b0;
        h_empty_en_s  = 1'b0;
        s_kill_en_s   = 1'b0;
        s_load_en_s   = 1'b0;
        s_empty_en_s  = 1'b0;
        s_hold_s      = 1'b0;
        h_load_data_s = i_Data;
        h_load_tag_s  = i_Checkpoint;
        if (i_Flush) begin
            h_kill_en_s = 1'b1;
            s_kill_en_s = 1'b1;
        end else begin
            if (h_stays_s) begin
                h_load_en_s = 1'b0;
            end else if (s_live_s) begin
                h_load_en_s   = 1'b1;
                h_load_data_s = s_data_s;
                h_load_tag_s  = s_tag_s;
            end else if (in_live_s) begin
                h_load_en_s = 1'b1;
            end else if (h_valid_s && h_hit_s) begin
                h_kill_en_s = 1'b1;
            end else if (h_valid_s) begin
                h_empty_en_s = 1'b1;
            end else begin
                h_empty_en_s = 1'b0;
            end

            if (h_stays_s && s_live_s) begin
                s_hold_s = 1'b1;
            end else if (in_live_s && (h_stays_s || s_live_s)) begin
                s_load_en_s = 1'b1;
            end else if (s_valid_s && s_hit_s) begin
                s_kill_en_s = 1'b1;
            end else if (s_valid_s) begin
                s_empty_en_s = 1'b1;
            end else begin
                s_empty_en_s = 1'b0;
            end
        end
    end

    pipe_skid_entry #(
        .DATA_WIDTH   (DATA_WIDTH),
        .TAG_WIDTH    (CHECKPOINT_WIDTH),
        .ZERO_ON_KILL (ZERO_ON_FLUSH)
    ) u_head (
        .clk       (i_Clk),
        .rst_n     (i_Reset_n),
        .kill_en   (h_kill_en_s),
        .load_en   (h_load_en_s),
        .empty_en  (h_empty_en_s),
        .load_data (h_load_data_s),
        .load_tag  (h_load_tag_s),
        .valid     (h_valid_s),
        .data      (h_data_s),
        .tag       (h_tag_s)
    );

    pipe_skid_entry #(
        .DATA_WIDTH   (DATA_WIDTH),
        .TAG_WIDTH    (CHECKPOINT_WIDTH),
        .ZERO_ON_KILL (ZERO_ON_FLUSH)
    ) u_skid (
        .clk       (i_Clk),
        .rst_n     (i_Reset_n),
        .kill_en   (s_kill_en_s),
        .load_en   (s_load_en_s),
        .empty_en  (s_empty_en_s),
        .load_data (i_Data),
        .load_tag  (i_Checkpoint),
        .valid     (s_valid_s),
        .data      (s_data_s),
        .tag       (s_tag_s)
    );

    // Ready flop: stage accepts next cycle exactly when the skid slot will be free.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            ready_r <= 1'b1;
        end else if (i_Flush) begin
            ready_r <= 1'b1;
        end else begin
            ready_r <= !(s_hold_s || s_load_en_s);
        end
    end

    // Saturating backpressure counter; clear takes precedence over increment.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            stall_cnt_r <= {COUNT_WIDTH{1'b0}};
        end else if (i_Count_Clear) begin
            stall_cnt_r <= {COUNT_WIDTH{1'b0}};
        end else if (h_stays_s && (stall_cnt_r != {COUNT_WIDTH{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // S is only ever occupied while H is, so the sum is {both, exactly one}.
    assign o_Occupancy   = {h_valid_s & s_valid_s, h_valid_s ^ s_valid_s};
    assign o_Valid       = h_live_s;
    assign o_Data        = h_data_s;
    assign o_Checkpoint  = h_tag_s;
    assign o_Ready       = ready_r;
    assign o_Stall_Count = stall_cnt_r;

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Self-checking bench for pipe_elastic_stage: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_pipe_elastic_stage;

    localparam int DW   = 16;
    localparam int CW   = 2;
    localparam int NC   = 4;
    localparam int CNTW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush, kill, vin, rdy_in, clr;
    logic [NC-1:0] kill_mask;
    logic [DW-1:0] din, dout;
    logic [CW-1:0] ckin, ckout;
    logic          rdy_out, vout;
    logic [1:0]    occ;
    logic [CNTW-1:0] stall;

    int checks = 0;
    int errors = 0;

    // Reference model: ordered list of live entries, accept flag, stall count.
    logic [DW-1:0] md[$];
    logic [CW-1:0] mt[$];
    logic          m_ready;
    int            m_cnt;

    always #5 clk = ~clk;

    pipe_elastic_stage #(
        .DATA_WIDTH(DW), .CHECKPOINT_WIDTH(CW), .NUM_CHECKPOINTS(NC),
        .ZERO_ON_FLUSH(1'b1), .COUNT_WIDTH(CNTW)
    ) dut (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_Flush(flush), .i_Kill(kill),
        .i_Kill_Mask(kill_mask), .i_Valid(vin), .o_Ready(rdy_out),
        .i_Data(din), .i_Checkpoint(ckin), .o_Valid(vout), .i_Ready(rdy_in),
        .o_Data(dout), .o_Checkpoint(ckout), .o_Occupancy(occ),
        .i_Count_Clear(clr), .o_Stall_Count(stall)
    );

    task automatic idle();
        flush = 1'b0; kill = 1'b0; kill_mask = 4'b0000; vin = 1'b0;
        rdy_in = 1'b0; clr = 1'b0; din = 16'h0000; ckin = 2'b00;
    endtask

    task automatic model_reset();
        md.delete(); mt.delete(); m_ready = 1'b1; m_cnt = 0;
    endtask

    // One clock: advance the model with the inputs seen at the edge.
    task automatic cycle();
        logic ev, tr, acc;
        logic [DW-1:0] nd[$];
        logic [CW-1:0] nt[$];
        @(posedge clk);
        ev  = (md.size() > 0) && !(kill && kill_mask[mt[0]]);
        tr  = ev && rdy_in;
        acc = vin && m_ready;
        if (clr) m_cnt = 0;
        else if (ev && !rdy_in && m_cnt != 15) m_cnt = m_cnt + 1;
        if (flush) begin
            md.delete(); mt.delete(); m_ready = 1'b1;
        end else begin
            foreach (md[i]) begin
                if (!(i == 0 && tr) && !(kill && kill_mask[mt[i]])) begin
                    nd.push_back(md[i]); nt.push_back(mt[i]);
                end
            end
            if (acc && !(kill && kill_mask[ckin])) begin
                nd.push_back(din); nt.push_back(ckin);
            end
            md = nd; mt = nt;
            m_ready = (md.size() < 2);
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        #7;
        checks += 6;
        if (vout !== 1'b0)     begin errors++; $display("FAIL reset_valid: got %0b want 0", vout); end
        if (dout !== 16'h0)    begin errors++; $display("FAIL reset_data: got %0h want 0", dout); end
        if (ckout !== 2'b00)   begin errors++; $display("FAIL reset_ckpt: got %0h want 0", ckout); end
        if (rdy_out !== 1'b1)  begin errors++; $display("FAIL reset_ready: got %0b want 1", rdy_out); end
        if (occ !== 2'd0)      begin errors++; $display("FAIL reset_occ: got %0d want 0", occ); end
        if (stall !== 4'd0)    begin errors++; $display("FAIL reset_stall: got %0d want 0", stall); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        idle();
        rdy_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            vin = 1'b1; din = 16'(k);
            cycle();
            checks += 3;
            if (vout !== 1'b1 || dout !== 16'(k)) begin errors++; $display("FAIL stream_data: got v=%0b d=%0h want v=1 d=%0h", vout, dout, k); end
            if (rdy_out !== 1'b1) begin errors++; $display("FAIL stream_ready: got %0b want 1", rdy_out); end
            if (occ > 2'd1)       begin errors++; $display("FAIL stream_occ: got %0d want <=1", occ); end
        end
        vin = 1'b0;
        cycle();
        checks++;
        if (vout !== 1'b0) begin errors++; $display("FAIL stream_drain: got %0b want 0", vout); end
    endtask

    task automatic test_back_to_back();
        idle();
        clr = 1'b1; cycle(); clr = 1'b0;
        vin = 1'b1; din = 16'hA0A0; ckin = 2'd0; cycle();
        din = 16'hB0B0; cycle();
        vin = 1'b0;
        checks += 2;
        if (occ !== 2'd2)     begin errors++; $display("FAIL bp_occ: got %0d want 2", occ); end
        if (rdy_out !== 1'b0) begin errors++; $display("FAIL bp_ready: got %0b want 0", rdy_out); end
        repeat (2) cycle();
        rdy_in = 1'b1; #1;
        checks += 4;
        if (stall !== 4'd3) begin errors++; $display("FAIL bp_stall: got %0d want 3", stall); end
        if (vout !== 1'b1 || dout !== 16'hA0A0) begin errors++; $display("FAIL bp_first: got v=%0b d=%0h want A0A0", vout, dout); end
        cycle();
        if (vout !== 1'b1 || dout !== 16'hB0B0) begin errors++; $display("FAIL bp_second: got v=%0b d=%0h want B0B0", vout, dout); end
        cycle();
        if (vout !== 1'b0 || occ !== 2'd0) begin errors++; $display("FAIL bp_empty: got v=%0b occ=%0d want 0/0", vout, occ); end
    endtask

    task automatic test_kill();
        idle();
        vin = 1'b1; din = 16'h1111; ckin = 2'd1; cycle();
        din = 16'h2222; ckin = 2'd2; cycle();
        vin = 1'b0;
        kill = 1'b1; kill_mask = 4'b0010; #1;
        checks += 4;
        if (vout !== 1'b0) begin errors++; $display("FAIL kill_gate: got %0b want 0", vout); end
        cycle();
        kill = 1'b0; kill_mask = 4'b0000; #1;
        if (vout !== 1'b1 || dout !== 16'h2222) begin errors++; $display("FAIL kill_compact: got v=%0b d=%0h want 2222", vout, dout); end
        if (ckout !== 2'd2) begin errors++; $display("FAIL kill_ckpt: got %0d want 2", ckout); end
        if (occ !== 2'd1)   begin errors++; $display("FAIL kill_occ: got %0d want 1", occ); end
        rdy_in = 1'b1; cycle();
        idle();
    endtask

    task automatic test_flush();
        idle();
        vin = 1'b1; din = 16'h3333; cycle();
        din = 16'h4444; cycle();
        flush = 1'b1; din = 16'h5555; cycle();
        flush = 1'b0; vin = 1'b0; #1;
        checks += 5;
        if (vout !== 1'b0)    begin errors++; $display("FAIL flush_valid: got %0b want 0", vout); end
        if (occ !== 2'd0)     begin errors++; $display("FAIL flush_occ: got %0d want 0", occ); end
        if (rdy_out !== 1'b1) begin errors++; $display("FAIL flush_ready: got %0b want 1", rdy_out); end
        if (dout !== 16'h0 || ckout !== 2'd0) begin errors++; $display("FAIL flush_zero: got d=%0h c=%0d want 0", dout, ckout); end
        cycle();
        if (vout !== 1'b0) begin errors++; $display("FAIL flush_drop: got %0b want 0", vout); end
    endtask

    task automatic test_saturate();
        idle();
        clr = 1'b1; cycle(); clr = 1'b0;
        vin = 1'b1; din = 16'h6666; cycle();
        vin = 1'b0;
        repeat ((2 ** CNTW) + 3) cycle();
        checks += 2;
        if (stall !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d want 15", stall); end
        clr = 1'b1; cycle(); clr = 1'b0;
        if (stall !== 4'd0) begin errors++; $display("FAIL sat_clear: got %0d want 0", stall); end
        rdy_in = 1'b1; cycle();
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        vin = 1'b1; din = 16'h7777; ckin = 2'd3; cycle();
        din = 16'h8888; cycle();
        vin = 1'b0;
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks += 5;
        if (vout !== 1'b0)    begin errors++; $display("FAIL areset_valid: got %0b want 0", vout); end
        if (dout !== 16'h0)   begin errors++; $display("FAIL areset_data: got %0h want 0", dout); end
        if (ckout !== 2'd0)   begin errors++; $display("FAIL areset_ckpt: got %0d want 0", ckout); end
        if (rdy_out !== 1'b1) begin errors++; $display("FAIL areset_ready: got %0b want 1", rdy_out); end
        if (occ !== 2'd0)     begin errors++; $display("FAIL areset_occ: got %0d want 0", occ); end
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic ev;
        for (int n = 0; n < 400; n++) begin
            vin       = 1'($urandom_range(0, 1));
            rdy_in    = (($urandom % 4) != 0);
            flush     = (($urandom % 25) == 0);
            kill      = (($urandom % 8) == 0);
            kill_mask = 4'($urandom);
            clr       = (($urandom % 40) == 0);
            din       = 16'($urandom);
            ckin      = 2'($urandom);
            #1;
            ev = (md.size() > 0) && !(kill && kill_mask[mt[0]]);
            checks += 4;
            if (vout !== ev)                  begin errors++; $display("FAIL rnd_valid @%0d: got %0b want %0b", n, vout, ev); end
            if (rdy_out !== m_ready)          begin errors++; $display("FAIL rnd_ready @%0d: got %0b want %0b", n, rdy_out, m_ready); end
            if (occ !== 2'(md.size()))        begin errors++; $display("FAIL rnd_occ @%0d: got %0d want %0d", n, occ, md.size()); end
            if (stall !== 4'(m_cnt))          begin errors++; $display("FAIL rnd_stall @%0d: got %0d want %0d", n, stall, m_cnt); end
            if (ev) begin
                checks++;
                if (dout !== md[0] || ckout !== mt[0]) begin errors++; $display("FAIL rnd_head @%0d: got %0h/%0d want %0h/%0d", n, dout, ckout, md[0], mt[0]); end
            end
            cycle();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_kill();
        test_flush();
        test_saturate();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
